// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier: one add/subtract/shift step per clock,
// start/busy/done handshake, full 2*WIDTH-bit signed product on o_hi/o_lo.
module booth_mul_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_mcand,
    input  logic [WIDTH-1:0] i_mplier,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           r_state;
    logic [WIDTH:0]   r_m;
    logic [WIDTH:0]   r_a;
    logic [WIDTH-1:0] r_q;
    logic             r_qm1;
    logic [CW-1:0]    r_count;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_a_next;
    logic [WIDTH-1:0] w_q_next;
    logic             w_qm1_next;

    // A and M carry one extra sign bit so A-M with M = -2^(WIDTH-1) cannot overflow.
    always_comb begin
        case ({r_q[0], r_qm1})
            2'b01:   w_sum = r_a + r_m;
            2'b10:   w_sum = r_a - r_m;
            default: w_sum = r_a;
        endcase
        w_a_next   = {w_sum[WIDTH], w_sum[WIDTH:1]};
        w_q_next   = {w_sum[0], r_q[WIDTH-1:1]};
        w_qm1_next = r_q[0];
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= StIdle;
            r_m     <= '0;
            r_a     <= '0;
            r_q     <= '0;
            r_qm1   <= 1'b0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_m     <= {i_mcand[WIDTH-1], i_mcand};
                        r_q     <= i_mplier;
                        r_a     <= '0;
                        r_qm1   <= 1'b0;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    r_a     <= w_a_next;
                    r_q     <= w_q_next;
                    r_qm1   <= w_qm1_next;
                    r_count <= r_count + 1'b1;
                    if (r_count == LastCount) begin
                        r_hi    <= w_a_next[WIDTH-1:0];
                        r_lo    <= w_q_next;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: directed vector table, random operands
// against a plain-arithmetic signed product, and handshake corner sequences.
module tb_booth_mul_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         clr = 1'b1;
    logic         i_start = 1'b0;
    logic [W-1:0] i_mcand = '0;
    logic [W-1:0] i_mplier = '0;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_hi;
    logic [W-1:0] o_lo;

    int errors = 0;
    int checks = 0;
    logic [2*W-1:0] last_prod = '0;

    booth_mul_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .clr      (clr),
        .i_start  (i_start),
        .i_mcand  (i_mcand),
        .i_mplier (i_mplier),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_hi     (o_hi),
        .o_lo     (o_lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   m;
        logic [W-1:0]   q;
        logic [2*W-1:0] p;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [2*W-1:0] act,
                         input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return sa * sb;
    endfunction

    // One full multiply from IDLE: checks busy length, done latency, product, done width.
    task automatic run_mul(input logic [W-1:0] m, input logic [W-1:0] q,
                           input logic [2*W-1:0] exp, input string name);
        int n;
        int busy_cnt;
        i_mcand  = m;
        i_mplier = q;
        i_start  = 1'b1;
        tick();
        i_start  = 1'b0;
        i_mcand  = $urandom;
        i_mplier = $urandom;
        n = 1;
        busy_cnt = 0;
        while (!o_done && n < 100) begin
            if (o_busy) busy_cnt++;
            tick();
            n++;
        end
        check({name, "_done_latency"}, 64'(n), 64'(W + 1));
        check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(W));
        check({name, "_product"}, {o_hi, o_lo}, exp);
        check({name, "_busy_at_done"}, 64'(o_busy), 64'(0));
        last_prod = {o_hi, o_lo};
        tick();
        check({name, "_done_pulse_width"}, 64'(o_done), 64'(0));
    endtask

    initial begin
        vec_t vecs[5];
        int pulses;
        int n;
        logic [2*W-1:0] prod;
        logic [W-1:0] a;
        logic [W-1:0] b;

        vecs[0] = '{32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F};
        vecs[1] = '{32'hFFFF_FFF9, 32'h0000_0006, 64'hFFFF_FFFF_FFFF_FFD6};
        vecs[2] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
        vecs[4] = '{32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780};

        // Reset, then idle with everything low.
        tick();
        tick();
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("reset_busy", 64'(o_busy), 64'(0));
            check("reset_done", 64'(o_done), 64'(0));
            check("reset_prod", {o_hi, o_lo}, 64'(0));
            tick();
        end

        for (int i = 0; i < 5; i++) begin
            run_mul(vecs[i].m, vecs[i].q, vecs[i].p, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 5 == 1) a = 32'h8000_0000;
            if (i % 5 == 2) b = 32'h7FFF_FFFF;
            if (i % 5 == 3) a = 32'(-int'($urandom_range(0, 3)));
            run_mul(a, b, ref_mul(a, b), $sformatf("rand%0d", i));
        end

        // A second start while busy must be ignored, with new operands on the bus.
        i_mcand  = 32'h1234_5678;
        i_mplier = 32'h0000_0010;
        i_start  = 1'b1;
        tick();
        i_start  = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        i_mcand  = 32'h0000_0007;
        i_mplier = 32'h0000_0009;
        i_start  = 1'b1;
        tick();
        i_start  = 1'b0;
        pulses = 0;
        prod = '0;
        for (int i = 0; i < 60; i++) begin
            if (o_done) begin
                pulses++;
                prod = {o_hi, o_lo};
            end
            tick();
        end
        check("busy_start_pulses", 64'(pulses), 64'(1));
        check("busy_start_product", prod, 64'h0000_0001_2345_6780);
        last_prod = prod;

        // Start held high: ignored in DONE, accepted again from IDLE.
        i_mcand  = 32'd3;
        i_mplier = 32'd5;
        i_start  = 1'b1;
        tick();
        n = 0;
        while (!o_done && n < 100) begin
            tick();
            n++;
        end
        check("held_start_first_done", 64'(o_done), 64'(1));
        tick();
        check("held_start_ignored_in_done", 64'(o_busy), 64'(0));
        tick();
        check("held_start_from_idle", 64'(o_busy), 64'(1));
        i_start = 1'b0;
        n = 0;
        while (!o_done && n < 100) begin
            tick();
            n++;
        end
        check("held_start_second_product", {o_hi, o_lo}, 64'd15);
        last_prod = {o_hi, o_lo};
        tick();

        // clr during RUN aborts: outputs cleared, no done pulse.
        i_mcand  = 32'd4;
        i_mplier = 32'd4;
        i_start  = 1'b1;
        tick();
        i_start  = 1'b0;
        for (int i = 1; i < 15; i++) tick();
        check("abort_busy_mid_run", 64'(o_busy), 64'(1));
        check("abort_hold_prev_product", {o_hi, o_lo}, last_prod);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("abort_busy", 64'(o_busy), 64'(0));
        check("abort_done", 64'(o_done), 64'(0));
        check("abort_prod", {o_hi, o_lo}, 64'(0));
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (o_done) pulses++;
            tick();
        end
        check("abort_no_done", 64'(pulses), 64'(0));
        run_mul(32'd2, 32'd2, 64'd4, "after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
- Sequential signed multiplier for the Mini SRC datapath, implementing the MUL instruction.
- Radix-2 Booth recoding: one add/subtract/shift step per clock.
- Sits beside the 32-bit carry-lookahead adder stage in the ALU.
- Produces the 64-bit product that the HI/LO registers consume, and holds the ALU busy through a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand width in bits. Product is 2*WIDTH bits. Iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  synchronous active-high reset.
- i_start  input  1  request a multiply; sampled only in IDLE.
- i_mcand  input  WIDTH  multiplicand M, two's complement.
- i_mplier  input  WIDTH  multiplier Q, two's complement.
- o_busy  output  1  high while iterating (RUN state).
- o_done  output  1  single-cycle pulse when the product is valid.
- o_hi  output  WIDTH  product bits [2*WIDTH-1:WIDTH].
- o_lo  output  WIDTH  product bits [WIDTH-1:0].

Behaviour:
- Reset:
  - clr=1 at any clock edge forces state=IDLE, o_busy=0, o_done=0, o_hi=0, o_lo=0, iteration count=0.
  - clr has priority over all other inputs.
  - clr during RUN aborts the operation; no partial product is ever written to o_hi/o_lo.
- States: IDLE, RUN, DONE.
- IDLE:
  - i_start=1 at an edge latches M<=i_mcand, Q<=i_mplier, A<=0, q_m1<=0, count<=0, then state<=RUN.
  - i_start=0: state stays IDLE.
- RUN, one step per edge:
  - Q[0],q_m1=01: A<=A+M.
  - Q[0],q_m1=10: A<=A-M.
  - 00 or 11: A unchanged.
  - The sum is then arithmetic-right-shifted as the concatenation {A,Q,q_m1}.
  - count<=count+1.
- Width rule:
  - A is held as WIDTH+1 bits, sign-extended from M, so A-M for M=-2^(WIDTH-1) cannot overflow.
  - The add/subtract is a WIDTH+1-bit two's-complement operation; carry-out is discarded.
- RUN exit:
  - On the edge where count==WIDTH-1, the final step is applied and state<=DONE.
  - o_hi/o_lo are loaded with the shifted result, low WIDTH bits of A to o_hi and Q to o_lo.
  - o_done<=1 on the same edge.
- DONE: lasts one cycle. Next edge sets o_done<=0 and state<=IDLE.
  - i_start in DONE is ignored; a new start is accepted from IDLE, so back-to-back issue costs one idle cycle.
- Latency:
  - o_busy rises the cycle after the start edge and stays high for exactly WIDTH cycles.
  - o_done is high during cycle WIDTH+1 after the start-sampling edge.
- i_start while busy: ignored. Latched operands are unaffected by input changes after the start edge.
- Output hold: o_hi/o_lo hold the last product until the next completed multiply or clr.
  - They are not cleared at the start of a new operation.
- Signed semantics: the result equals the full 2*WIDTH-bit two's-complement product for all operand pairs, including both operands at the most negative value.

Test Plan:
- clr pulse, then idle 3 cycles -> o_hi=0, o_lo=0, o_busy=0, o_done=0 throughout.
- i_mcand=3, i_mplier=5, 1-cycle i_start:
  - o_busy high 32 cycles.
  - o_done pulses exactly 33 cycles after the start edge.
  - o_hi=0x00000000, o_lo=0x0000000F.
- i_mcand=-7 (0xFFFFFFF9), i_mplier=6 -> o_hi=0xFFFFFFFF, o_lo=0xFFFFFFD6.
- Negative edge cases:
  - i_mcand=i_mplier=0x80000000 -> o_hi=0x40000000, o_lo=0x00000000.
  - i_mcand=i_mplier=0xFFFFFFFF -> o_hi=0, o_lo=1.
- Start 0x12345678 x 0x10 (result 0x1, 0x23456780), then on cycle 10 drive a second i_start with new operands:
  - the second start is ignored;
  - result stays 0x1, 0x23456780;
  - o_done pulses once.
- Start 4x4, assert clr on cycle 15 of RUN:
  - next cycle o_busy=0, o_hi/o_lo=0;
  - no o_done pulse;
  - a subsequent 2x2 returns o_lo=4.
